// File: rtl/wordlines_comp_pipe.sv
// Two-stage wordline decoder: registers read/write row requests, flags same-row
// read/write collisions, and drives registered one-hot wordlines to both subarray halves.
module wordlines_comp_pipe #(
   parameter int ROWS  = 64,
   parameter int AW    = $clog2(ROWS),
   parameter int NRD   = 2,
   parameter bit SPLIT = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold,
   input  logic [0:NRD-1]       rd_v,
   input  logic [0:NRD*AW-1]    rd_addr,
   input  logic                 wr_v,
   input  logic [0:AW-1]        wr_addr,
   output logic [0:NRD*ROWS-1]  rwl_l,
   output logic [0:NRD*ROWS-1]  rwl_r,
   output logic [0:ROWS-1]      wwl_l,
   output logic [0:ROWS-1]      wwl_r,
   output logic [0:NRD-1]       collide
);

   logic [0:NRD-1]      rd_vld_p0;
   logic [0:NRD-1]      collide_p0;
   logic [AW-1:0]       rd_addr_p0 [NRD];
   logic                wr_vld_p0;
   logic [AW-1:0]       wr_addr_p0;

   logic [0:NRD*ROWS-1] rwl_l_d;
   logic [0:NRD*ROWS-1] rwl_r_d;
   logic [0:ROWS-1]     wwl_l_d;
   logic [0:ROWS-1]     wwl_r_d;
   logic [0:ROWS-1]     rd_row;
   logic [0:ROWS-1]     wr_row;

   function automatic logic [0:ROWS-1] decode(input logic en, input logic [AW-1:0] a);
      logic [0:ROWS-1] v;
      v = '0;
      if (en) v[a] = 1'b1;
      return v;
   endfunction

   // With SPLIT, the address MSB picks the half, so only the matching half keeps its rows.
   function automatic logic [0:ROWS-1] route(input logic [0:ROWS-1] v, input logic right);
      logic [0:ROWS-1] o;
      o = '0;
      for (int r = 0; r < ROWS; r++)
         if (!SPLIT || ((r >= ROWS/2) == right)) o[r] = v[r];
      return o;
   endfunction

   // Stage A: capture requests and resolve collisions
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_vld_p0  <= '0;
         collide_p0 <= '0;
         wr_vld_p0  <= 1'b0;
         wr_addr_p0 <= '0;
         for (int p = 0; p < NRD; p++) rd_addr_p0[p] <= '0;
      end else if (!hold) begin
         rd_vld_p0  <= rd_v;
         wr_vld_p0  <= wr_v;
         wr_addr_p0 <= wr_addr;
         for (int p = 0; p < NRD; p++) begin
            rd_addr_p0[p] <= rd_addr[p*AW +: AW];
            collide_p0[p] <= rd_v[p] & wr_v & (rd_addr[p*AW +: AW] == wr_addr);
         end
      end
   end

   // Stage B: decode; a colliding read is suppressed so the write owns the row
   always_comb begin
      rwl_l_d = '0;
      rwl_r_d = '0;
      rd_row  = '0;
      for (int p = 0; p < NRD; p++) begin
         rd_row = decode(rd_vld_p0[p] & ~collide_p0[p], rd_addr_p0[p]);
         rwl_l_d[p*ROWS +: ROWS] = route(rd_row, 1'b0);
         rwl_r_d[p*ROWS +: ROWS] = route(rd_row, 1'b1);
      end
      wr_row  = decode(wr_vld_p0, wr_addr_p0);
      wwl_l_d = route(wr_row, 1'b0);
      wwl_r_d = route(wr_row, 1'b1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rwl_l   <= '0;
         rwl_r   <= '0;
         wwl_l   <= '0;
         wwl_r   <= '0;
         collide <= '0;
      end else if (!hold) begin
         rwl_l   <= rwl_l_d;
         rwl_r   <= rwl_r_d;
         wwl_l   <= wwl_l_d;
         wwl_r   <= wwl_r_d;
         collide <= collide_p0;
      end
   end

   a_wwl_l_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(wwl_l));
   a_wwl_r_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(wwl_r));

   for (genvar p = 0; p < NRD; p++) begin : g_chk
      a_rd_l_onehot: assert property (@(posedge clk) disable iff (reset)
         $onehot0(rwl_l[p*ROWS +: ROWS]));
      a_rd_r_onehot: assert property (@(posedge clk) disable iff (reset)
         $onehot0(rwl_r[p*ROWS +: ROWS]));
      a_no_shared_l: assert property (@(posedge clk) disable iff (reset)
         (rwl_l[p*ROWS +: ROWS] & wwl_l) == '0);
      a_no_shared_r: assert property (@(posedge clk) disable iff (reset)
         (rwl_r[p*ROWS +: ROWS] & wwl_r) == '0);
      a_collide_quiet: assert property (@(posedge clk) disable iff (reset)
         collide[p] |-> ((rwl_l[p*ROWS +: ROWS] == '0) && (rwl_r[p*ROWS +: ROWS] == '0)));
   end

endmodule

// File: tb/tb_wordlines_comp_pipe.sv
// Directed-vector bench for wordlines_comp_pipe: one replicate (SPLIT=0) and one
// split (SPLIT=1) instance share the same stimulus.
module tb_wordlines_comp_pipe;

   localparam int ROWS = 64;
   localparam int AW   = 6;
   localparam int NRD  = 2;

   typedef struct {
      bit rv0; bit rv1; int a0; int a1; bit wv; int wa;
      int er0; int er1; int ew; bit ec0; bit ec1;
   } vec_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                hold;
   logic [0:NRD-1]      rd_v;
   logic [0:NRD*AW-1]   rd_addr;
   logic                wr_v;
   logic [0:AW-1]       wr_addr;

   logic [0:NRD*ROWS-1] d0_rwl_l, d0_rwl_r, d1_rwl_l, d1_rwl_r;
   logic [0:ROWS-1]     d0_wwl_l, d0_wwl_r, d1_wwl_l, d1_wwl_r;
   logic [0:NRD-1]      d0_col, d1_col;

   int   total = 0;
   int   bad   = 0;
   vec_t vq[$];
   vec_t idle = '{0, 0, 0, 0, 0, 0, -1, -1, -1, 0, 0};

   always #5 clk = ~clk;

   wordlines_comp_pipe #(.ROWS(ROWS), .NRD(NRD), .SPLIT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .hold(hold), .rd_v(rd_v), .rd_addr(rd_addr),
      .wr_v(wr_v), .wr_addr(wr_addr), .rwl_l(d0_rwl_l), .rwl_r(d0_rwl_r),
      .wwl_l(d0_wwl_l), .wwl_r(d0_wwl_r), .collide(d0_col));

   wordlines_comp_pipe #(.ROWS(ROWS), .NRD(NRD), .SPLIT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .hold(hold), .rd_v(rd_v), .rd_addr(rd_addr),
      .wr_v(wr_v), .wr_addr(wr_addr), .rwl_l(d1_rwl_l), .rwl_r(d1_rwl_r),
      .wwl_l(d1_wwl_l), .wwl_r(d1_wwl_r), .collide(d1_col));

   function automatic logic [0:NRD*ROWS-1] exp_rwl(int r0, int r1, bit right, bit split);
      logic [0:NRD*ROWS-1] v;
      int rr[2];
      v = '0;
      rr[0] = r0;
      rr[1] = r1;
      for (int p = 0; p < NRD; p++)
         if (rr[p] >= 0 && (!split || ((rr[p] >= ROWS/2) == right))) v[p*ROWS + rr[p]] = 1'b1;
      return v;
   endfunction

   function automatic logic [0:ROWS-1] exp_wwl(int w, bit right, bit split);
      logic [0:ROWS-1] v;
      v = '0;
      if (w >= 0 && (!split || ((w >= ROWS/2) == right))) v[w] = 1'b1;
      return v;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic check_all(string nm, vec_t e);
      chk({nm, " d0.rwl_l"}, 128'(d0_rwl_l), 128'(exp_rwl(e.er0, e.er1, 1'b0, 1'b0)));
      chk({nm, " d0.rwl_r"}, 128'(d0_rwl_r), 128'(exp_rwl(e.er0, e.er1, 1'b1, 1'b0)));
      chk({nm, " d0.wwl_l"}, 128'(d0_wwl_l), 128'(exp_wwl(e.ew, 1'b0, 1'b0)));
      chk({nm, " d0.wwl_r"}, 128'(d0_wwl_r), 128'(exp_wwl(e.ew, 1'b1, 1'b0)));
      chk({nm, " d0.collide"}, 128'(d0_col), 128'({e.ec0, e.ec1}));
      chk({nm, " d1.rwl_l"}, 128'(d1_rwl_l), 128'(exp_rwl(e.er0, e.er1, 1'b0, 1'b1)));
      chk({nm, " d1.rwl_r"}, 128'(d1_rwl_r), 128'(exp_rwl(e.er0, e.er1, 1'b1, 1'b1)));
      chk({nm, " d1.wwl_l"}, 128'(d1_wwl_l), 128'(exp_wwl(e.ew, 1'b0, 1'b1)));
      chk({nm, " d1.wwl_r"}, 128'(d1_wwl_r), 128'(exp_wwl(e.ew, 1'b1, 1'b1)));
      chk({nm, " d1.collide"}, 128'(d1_col), 128'({e.ec0, e.ec1}));
   endtask

   task automatic drive(vec_t v);
      rd_v    = {v.rv0, v.rv1};
      rd_addr = {AW'(v.a0), AW'(v.a1)};
      wr_v    = v.wv;
      wr_addr = AW'(v.wa);
   endtask

   // Back-to-back issue: the vector driven at negedge i is checked at negedge i+2.
   task automatic run_queue(string tag);
      int n;
      n = vq.size();
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         if (i >= 2) check_all($sformatf("%s[%0d]", tag, i - 2), vq[i-2]);
         if (i < n) drive(vq[i]);
         else drive(idle);
      end
      vq.delete();
   endtask

   initial begin
      vec_t v5, v9, h3, h9, r;
      v5 = '{1, 0, 5, 0, 0, 0, 5, -1, -1, 0, 0};
      v9 = '{1, 0, 9, 0, 0, 0, 9, -1, -1, 0, 0};
      h3 = '{1, 0, 3, 0, 0, 0, 3, -1, -1, 0, 0};
      h9 = '{1, 0, 9, 0, 0, 0, 9, -1, -1, 0, 0};

      reset = 1'b1;
      hold  = 1'b0;
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset", idle);
      reset = 1'b0;

      // Reset in mid-stream: outputs clear asynchronously, in-flight request dropped
      drive(v5);
      @(negedge clk);
      drive(v9);
      @(posedge clk);
      #2;
      check_all("pre_rst", v5);
      reset = 1'b1;
      #1;
      check_all("async_rst", idle);
      @(negedge clk);
      reset = 1'b0;
      drive(idle);
      @(negedge clk);
      check_all("rst_flush", idle);
      drive(v5);
      @(negedge clk);
      drive(idle);
      check_all("post_rst_e1", idle);
      @(negedge clk);
      check_all("post_rst_e2", v5);
      @(negedge clk);
      check_all("post_rst_e3", idle);

      // Directed table
      vq.push_back('{1, 0,  5,  0, 0,  0,  5, -1, -1, 0, 0});
      vq.push_back('{1, 1, 12, 12, 1, 12, -1, -1, 12, 1, 1});
      vq.push_back('{1, 0, 12,  0, 1, 13, 12, -1, 13, 0, 0});
      vq.push_back('{0, 1,  0, 40, 0,  0, -1, 40, -1, 0, 0});
      vq.push_back('{0, 1,  0,  7, 0,  0, -1,  7, -1, 0, 0});
      vq.push_back('{1, 1, 20, 20, 0,  0, 20, 20, -1, 0, 0});
      vq.push_back('{1, 0,  0,  0, 1, 63,  0, -1, 63, 0, 0});
      vq.push_back('{1, 1, 33,  2, 1, 33, -1,  2, 33, 1, 0});
      vq.push_back('{0, 0,  9, 44, 0, 17, -1, -1, -1, 0, 0});
      vq.push_back('{1, 1, 63,  0, 1, 31, 63,  0, 31, 0, 0});
      vq.push_back('{0, 1, 17, 50, 1, 17, -1, 50, 17, 0, 0});
      vq.push_back('{1, 1, 31, 32, 1, 32, 31, -1, 32, 0, 1});
      run_queue("table");

      // Walking write decode, then write invalid
      for (int w = 0; w < ROWS; w++) vq.push_back('{0, 0, 0, 0, 1, w, -1, -1, w, 0, 0});
      vq.push_back('{0, 0, 0, 0, 0, 21, -1, -1, -1, 0, 0});
      run_queue("walk");

      // Hold: output frozen for three edges, then pipeline resumes
      @(negedge clk);
      drive(h3);
      @(negedge clk);
      drive(idle);
      @(negedge clk);
      check_all("hold_pre", h3);
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_all($sformatf("hold_%0d", k), h3);
      end
      hold = 1'b0;
      drive(h9);
      @(negedge clk);
      drive(idle);
      check_all("hold_rel", idle);
      @(negedge clk);
      check_all("hold_next", h9);
      @(negedge clk);
      check_all("hold_done", idle);

      // Random regression against the behavioural rule
      for (int i = 0; i < 300; i++) begin
         r.rv0 = 1'($urandom_range(0, 1));
         r.rv1 = 1'($urandom_range(0, 1));
         r.wv  = 1'($urandom_range(0, 1));
         r.a0  = int'($urandom_range(0, ROWS - 1));
         r.a1  = ($urandom_range(0, 3) == 0) ? r.a0 : int'($urandom_range(0, ROWS - 1));
         r.wa  = ($urandom_range(0, 1) == 0) ? r.a0 : int'($urandom_range(0, ROWS - 1));
         r.ec0 = r.rv0 && r.wv && (r.a0 == r.wa);
         r.ec1 = r.rv1 && r.wv && (r.a1 == r.wa);
         r.er0 = (r.rv0 && !r.ec0) ? r.a0 : -1;
         r.er1 = (r.rv1 && !r.ec1) ? r.a1 : -1;
         r.ew  = r.wv ? r.wa : -1;
         vq.push_back(r);
      end
      run_queue("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
